// File: rtl/rs232_rx.sv
`default_nettype none
// ============================================================================
// Module  : rs232_rx
// Brief   : Asynchronous serial receiver (8 data bits, LSB first, 1 stop bit).
//           Define RS232_RX_PARITY_EN to receive and check a parity bit.
// Revision: 1.0
// ============================================================================
module rs232_rx #(
  parameter int Width = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [Width-1:0] baud_i,
  input  logic             psel_i,
  output logic [7:0]       d_o,
  output logic             eor_o,
  output logic             perr_o,
  output logic             ferr_o,
  output logic             busy_o
);

`ifdef RS232_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  localparam logic [2:0] c_LAST_BIT = 3'd7;

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [Width-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic             r_armed;
  logic [7:0]       r_d;
  logic             r_eor;
  logic             r_ferr;
  logic             r_perr;

  logic             w_rx;
  logic [Width-1:0] w_half;
  logic             w_half_hit;
  logic             w_bit_hit;

  assign w_rx       = r_sync[1];
  assign w_half     = baud_i >> 1;
  assign w_half_hit = (r_cnt == w_half);
  assign w_bit_hit  = (r_cnt == baud_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

`ifdef RS232_RX_PARITY_EN
  logic r_perr_pend;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perr_pend <= 1'b0;
    end else if (r_state == S_PARITY && w_bit_hit) begin
      // Mismatch between received and selected parity flags an error.
      r_perr_pend <= (^r_shift) ^ w_rx ^ psel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perr <= 1'b0;
    end else if (r_state == S_STOP && w_bit_hit) begin
      r_perr <= r_perr_pend;
    end
  end
`else
  logic w_unused_psel;
  assign w_unused_psel = psel_i;
  assign r_perr        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_armed  <= 1'b0;
      r_d      <= 8'h00;
      r_eor    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_eor <= 1'b0;
      if (w_rx) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A break (stop bit low) disarms detection until the line idles high.
          if (!w_rx && r_armed) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_half_hit) begin
            r_cnt    <= '0;
            r_bitcnt <= 3'd0;
            r_state  <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_hit) begin
            r_cnt    <= '0;
            r_shift  <= {w_rx, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == c_LAST_BIT) begin
`ifdef RS232_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef RS232_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_d     <= r_shift;
            r_ferr  <= ~w_rx;
            r_eor   <= 1'b1;
            if (!w_rx) begin
              r_armed <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign d_o    = r_d;
  assign eor_o  = r_eor;
  assign perr_o = r_perr;
  assign ferr_o = r_ferr;
  assign busy_o = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 Parameter Width, default 15, bit width of baud_i and the internal baud counter.
REQ-002 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 rx_i  input  1  serial line; idle high; asynchronous to clk_i.
REQ-005 baud_i  input  Width  clocks per bit minus 1 (867 for 100 MHz / 115200); held static during a frame.
REQ-006 psel_i  input  1  parity select: 0 = even, 1 = odd; used only when parity is compiled in.
REQ-007 d_o  output  8  last received data byte.
REQ-008 eor_o  output  1  end of reception; one-cycle pulse per completed frame.
REQ-009 perr_o  output  1  parity error flag of the last frame.
REQ-010 ferr_o  output  1  framing error flag of the last frame (stop bit sampled low).
REQ-011 busy_o  output  1  high from start-bit detection until eor_o.

Function
REQ-012 rx_i shall pass through a 2-flop synchronizer, with both flops reset to 1, before any use.
REQ-013 Frame format: start (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on the synchronized rx going low; the baud counter clears to 0.
REQ-016 START: at count == baud_i>>1, a sample of 0 clears the counter and enters DATA; a sample of 1 is a false start and returns to IDLE with no eor_o.
REQ-017 DATA: each bit is sampled when count == baud_i (mid-bit), then the counter clears; after the 8th bit go to PARITY if compiled in, else to STOP.
REQ-018 PARITY: sample at count == baud_i; perr = XOR(data, parity bit) XOR psel_i; perr = 1 on mismatch.
REQ-019 STOP: sample at count == baud_i; ferr = ~sample; next state is IDLE.
REQ-020 The cycle after the stop sample, d_o, perr_o and ferr_o shall update together and eor_o shall pulse for exactly one cycle.
REQ-021 d_o, perr_o and ferr_o shall hold their values until the next eor_o.
REQ-022 A frame with ferr set still delivers d_o and eor_o.
REQ-023 After a low stop bit, IDLE shall not re-trigger until the synchronized rx has been seen high at least once (no break-induced frame storm).
REQ-024 busy_o = (state != IDLE).
REQ-025 The baud counter is Width bits wide and never wraps within a bit; baud_i values below 3 are unsupported.

Reset
REQ-026 When rst_i is low: state = IDLE, counter = 0, shift register = 0, d_o = 0x00, eor_o = 0, perr_o = 0, ferr_o = 0, busy_o = 0, synchronizer = 1.
REQ-027 Reset asserted mid-frame shall abort the frame with no eor_o; reception restarts only on a new falling edge after release.

Configuration
REQ-028 Macro RS232_RX_PARITY_EN defined: the frame includes the parity bit and the PARITY state; perr_o is computed as in REQ-018.
REQ-029 Macro RS232_RX_PARITY_EN undefined: 8N1 frames, the PARITY state is absent, perr_o is tied 0, and psel_i is ignored.

Verification
REQ-030 baud_i=867, 8N1, byte 0xA5 -> one eor_o pulse, d_o=0xA5, perr_o=0, ferr_o=0, busy_o high for about 9.5 bit times.
REQ-031 Parity build, psel_i=0, 0x03 sent with parity 0 -> perr_o=0; same byte with parity 1 -> perr_o=1 and d_o=0x03.
REQ-032 Stop bit forced low on 0x55 -> d_o=0x55, ferr_o=1, eor_o pulses once; line held low afterwards -> no further eor_o until rx returns high.
REQ-033 Low glitch on rx_i of 100 clocks (shorter than half a bit) -> no eor_o, busy_o returns low, d_o unchanged.
REQ-034 rst_i pulled low during the 4th data bit, then 0x3C sent -> no eor_o for the aborted frame; d_o=0x3C after the next frame.
REQ-035 Back-to-back frames 0x00 then 0xFF with no idle gap -> two eor_o pulses, d_o=0x00 then 0xFF.
